// File: rtl/ram_pkg.sv
// Shared constants, response type and address check for the ram request
// front-end.
//   RAM_AW/RAM_DW : address / data width seen on the request ports
//   RAM_DEPTH     : number of RAM words; addresses at or above it are rejected
//   RD_STAGES     : edges between read accept and response capture
//   ram_rsp_t     : one response FIFO entry {data, err}
//   addr_ok()     : 1 when an address falls inside the RAM
package ram_pkg;
  localparam int RAM_AW    = 5;
  localparam int RAM_DW    = 8;
  localparam int RAM_DEPTH = 16;
  localparam int RD_STAGES = 2;

  typedef struct packed {
    logic [RAM_DW-1:0] data;
    logic              err;
  } ram_rsp_t;

  function automatic logic addr_ok(input logic [RAM_AW-1:0] addr);
    return addr < RAM_AW'(RAM_DEPTH);
  endfunction
endpackage

// File: rtl/ram_rsp_fifo.sv
// Response FIFO for read results, kept in request order.
//   clk, rst   : clock, async active-low reset
//   push       : write push_data at the tail
//   pop        : drop the head entry (caller only pops when count != 0)
//   head       : current head entry, zero while empty
//   count      : number of stored entries
module ram_rsp_fifo
  import ram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  ram_rsp_t                 push_data,
  input  logic                     pop,
  output ram_rsp_t                 head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  ram_rsp_t          mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;

  // storage needs no reset: nothing is visible until count says so
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their own
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = (count != '0) ? mem[rptr] : '0;
endmodule

// File: rtl/ram_req_ctrl.sv
// Request front-end for the 16x8 ram block.
//   clk, rst                 : clock, async active-low reset
//   wr_valid/wr_ready        : write request handshake (wr_addr, wr_data)
//   rd_valid/rd_ready        : read request handshake (rd_addr)
//   rsp_valid/rsp_ready      : read response handshake (rsp_data, rsp_err)
//   err_cnt                  : saturating count of out-of-range requests
//   ram_enb/wr/rd, ram_w_addr, ram_w_data, ram_r_addr : to ram inputs
//   ram_r_data               : from ram r_data
// Reads return in order through a credit-limited FIFO; a read to the address
// being written in the same cycle is held back one cycle so it sees new data.
module ram_req_ctrl
  import ram_pkg::*;
#(
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [RAM_AW-1:0] wr_addr,
  input  logic [RAM_DW-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [RAM_AW-1:0] rd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RAM_DW-1:0] rsp_data,
  output logic              rsp_err,
  output logic [7:0]        err_cnt,
  output logic              ram_enb,
  output logic              ram_wr,
  output logic              ram_rd,
  output logic [RAM_AW-1:0] ram_w_addr,
  output logic [RAM_AW-1:0] ram_r_addr,
  output logic [RAM_DW-1:0] ram_w_data,
  input  logic [RAM_DW-1:0] ram_r_data
);
  localparam int             CW       = $clog2(RSP_DEPTH) + 1;
  localparam logic [CW-1:0]  CRED_MAX = CW'(RSP_DEPTH);

  logic                 wr_acc, rd_acc, wr_go, rd_go, wr_bad, rd_bad, rsp_pop;
  logic [CW-1:0]        credits, fifo_cnt;
  logic [RD_STAGES:1]   vld_pipe, err_pipe;
  logic [8:0]           err_sum;
  ram_rsp_t             cap, head;

  // ready drops combinationally with reset so nothing is taken while held
  assign wr_ready = rst;
  assign rd_ready = rst && (credits < CRED_MAX) &&
                    !(wr_valid && (wr_addr == rd_addr));

  assign wr_acc = wr_valid && wr_ready;
  assign rd_acc = rd_valid && rd_ready;
  assign wr_go  = wr_acc && addr_ok(wr_addr);
  assign rd_go  = rd_acc && addr_ok(rd_addr);
  assign wr_bad = wr_acc && !addr_ok(wr_addr);
  assign rd_bad = rd_acc && !addr_ok(rd_addr);

  // issue registers: address/data held at zero when the port is unused
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_wr     <= 1'b0;
      ram_rd     <= 1'b0;
      ram_w_addr <= '0;
      ram_w_data <= '0;
      ram_r_addr <= '0;
    end else begin
      ram_wr     <= wr_go;
      ram_rd     <= rd_go;
      ram_w_addr <= wr_go ? wr_addr : '0;
      ram_w_data <= wr_go ? wr_data : '0;
      ram_r_addr <= rd_go ? rd_addr : '0;
    end
  end

  assign ram_enb = ram_wr | ram_rd;

  // tag pipeline: rejected reads ride along so responses stay in order
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      err_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_STAGES-1:1], rd_acc};
      err_pipe <= {err_pipe[RD_STAGES-1:1], rd_bad};
    end
  end

  assign cap = {err_pipe[RD_STAGES] ? '0 : ram_r_data, err_pipe[RD_STAGES]};

  // credits cover every read from accept to pop, so capture never overflows
  ram_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_pipe[RD_STAGES]),
    .push_data (cap),
    .pop       (rsp_pop),
    .head      (head),
    .count     (fifo_cnt)
  );

  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_data  = head.data;
  assign rsp_err   = head.err;
  assign rsp_pop   = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits <= '0;
    end else begin
      case ({rd_acc, rsp_pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: ;
      endcase
    end
  end

  // both ports can fail in one cycle, hence the 9-bit sum before clamping
  assign err_sum = {1'b0, err_cnt} + 9'(wr_bad) + 9'(rd_bad);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_cnt <= '0;
    else      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end
endmodule

// File: tb/tb_ram_req_ctrl.sv
module tb_ram_req_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [4:0] wr_addr, rd_addr, ram_w_addr, ram_r_addr;
  logic [7:0] wr_data, rsp_data, err_cnt, ram_w_data, ram_r_data;
  logic       ram_enb, ram_wr, ram_rd;

  always #5 clk = ~clk;

  ram_req_ctrl #(.RSP_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .err_cnt(err_cnt),
    .ram_enb(ram_enb), .ram_wr(ram_wr), .ram_rd(ram_rd),
    .ram_w_addr(ram_w_addr), .ram_r_addr(ram_r_addr),
    .ram_w_data(ram_w_data), .ram_r_data(ram_r_data)
  );

  // downstream 16x8 ram: registered read, write on the edge
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_enb && ram_wr) mem[ram_w_addr[3:0]] <= ram_w_data;
    if (ram_enb && ram_rd) ram_r_data <= mem[ram_r_addr[3:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       wv;  logic [4:0] wa; logic [7:0] wd;
    logic       rv;  logic [4:0] ra;
    logic       e_rdy;
    logic [2:0] e_ram;            // {enb, wr, rd}
    logic [4:0] e_wa; logic [7:0] e_wd; logic [4:0] e_ra;
    logic       e_v; logic [7:0] e_d; logic e_err;
    logic [7:0] e_ec;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic wv, input logic [4:0] wa, input logic [7:0] wd,
                     input logic rv, input logic [4:0] ra, input logic e_rdy,
                     input logic [2:0] e_ram, input logic [4:0] e_wa,
                     input logic [7:0] e_wd, input logic [4:0] e_ra,
                     input logic e_v, input logic [7:0] e_d, input logic e_err,
                     input logic [7:0] e_ec);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.e_rdy = e_rdy;
    v.e_ram = e_ram; v.e_wa = e_wa; v.e_wd = e_wd; v.e_ra = e_ra;
    v.e_v = e_v; v.e_d = e_d; v.e_err = e_err; v.e_ec = e_ec;
    tv.push_back(v);
  endtask

  logic [4:0] bp_addr [6];
  logic [7:0] bp_exp  [6];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       rdy_s, v_s, e_s, any_enb, stay0;
    logic [7:0] d_s;
    int         acc, got;

    wr_valid = 0; wr_addr = 0; wr_data = 0; rd_valid = 0; rd_addr = 0; rsp_ready = 1;
    bp_addr = '{5'd3, 5'd1, 5'd2, 5'd7, 5'd1, 5'd3};
    bp_exp  = '{8'hA5, 8'h01, 8'h02, 8'h3C, 8'h01, 8'hA5};

    #12;
    chk("reset_ctl", {wr_ready, rd_ready, rsp_valid, rsp_err, ram_enb, ram_wr, ram_rd}, 0);
    chk("reset_data", {rsp_data, err_cnt, ram_w_data, ram_w_addr, ram_r_addr}, 0);
    @(negedge clk); rst = 1;

    //  wv wa    wd     rv ra    rdy ram     ewa   ewd    era   v  d      err ec
    add(1, 5'd3, 8'hA5, 0, 5'd0, 1, 3'b110, 5'd3, 8'hA5, 5'd0, 0, 8'h00, 0, 8'd0);
    add(0, 5'd0, 8'h00, 1, 5'd3, 1, 3'b101, 5'd0, 8'h00, 5'd3, 0, 8'h00, 0, 8'd0);
    add(0, 5'd0, 8'h00, 0, 5'd0, 1, 3'b000, 5'd0, 8'h00, 5'd0, 0, 8'h00, 0, 8'd0);
    add(0, 5'd0, 8'h00, 0, 5'd0, 1, 3'b000, 5'd0, 8'h00, 5'd0, 1, 8'hA5, 0, 8'd0);
    add(0, 5'd0, 8'h00, 0, 5'd0, 1, 3'b000, 5'd0, 8'h00, 5'd0, 0, 8'h00, 0, 8'd0);
    add(1, 5'd7, 8'h11, 0, 5'd0, 1, 3'b110, 5'd7, 8'h11, 5'd0, 0, 8'h00, 0, 8'd0);
    add(1, 5'd7, 8'h3C, 1, 5'd7, 0, 3'b110, 5'd7, 8'h3C, 5'd0, 0, 8'h00, 0, 8'd0);
    add(0, 5'd0, 8'h00, 1, 5'd7, 1, 3'b101, 5'd0, 8'h00, 5'd7, 0, 8'h00, 0, 8'd0);
    add(0, 5'd0, 8'h00, 0, 5'd0, 1, 3'b000, 5'd0, 8'h00, 5'd0, 0, 8'h00, 0, 8'd0);
    add(0, 5'd0, 8'h00, 0, 5'd0, 1, 3'b000, 5'd0, 8'h00, 5'd0, 1, 8'h3C, 0, 8'd0);
    add(1, 5'd1, 8'h01, 0, 5'd0, 1, 3'b110, 5'd1, 8'h01, 5'd0, 0, 8'h00, 0, 8'd0);
    add(1, 5'd2, 8'h02, 1, 5'd1, 1, 3'b111, 5'd2, 8'h02, 5'd1, 0, 8'h00, 0, 8'd0);
    add(0, 5'd0, 8'h00, 1, 5'd18,1, 3'b000, 5'd0, 8'h00, 5'd0, 0, 8'h00, 0, 8'd1);
    add(0, 5'd0, 8'h00, 1, 5'd2, 1, 3'b101, 5'd0, 8'h00, 5'd2, 1, 8'h01, 0, 8'd1);
    add(0, 5'd0, 8'h00, 0, 5'd0, 1, 3'b000, 5'd0, 8'h00, 5'd0, 1, 8'h00, 1, 8'd1);
    add(0, 5'd0, 8'h00, 0, 5'd0, 1, 3'b000, 5'd0, 8'h00, 5'd0, 1, 8'h02, 0, 8'd1);
    add(0, 5'd0, 8'h00, 0, 5'd0, 1, 3'b000, 5'd0, 8'h00, 5'd0, 0, 8'h00, 0, 8'd1);
    add(1, 5'd20,8'h55, 1, 5'd25,1, 3'b000, 5'd0, 8'h00, 5'd0, 0, 8'h00, 0, 8'd3);
    add(0, 5'd0, 8'h00, 0, 5'd0, 1, 3'b000, 5'd0, 8'h00, 5'd0, 0, 8'h00, 0, 8'd3);
    add(0, 5'd0, 8'h00, 0, 5'd0, 1, 3'b000, 5'd0, 8'h00, 5'd0, 1, 8'h00, 1, 8'd3);
    add(0, 5'd0, 8'h00, 0, 5'd0, 1, 3'b000, 5'd0, 8'h00, 5'd0, 0, 8'h00, 0, 8'd3);

    foreach (tv[i]) begin
      @(negedge clk);
      wr_valid = tv[i].wv; wr_addr = tv[i].wa; wr_data = tv[i].wd;
      rd_valid = tv[i].rv; rd_addr = tv[i].ra;
      #1;
      chk($sformatf("v%0d rd_ready", i), rd_ready, tv[i].e_rdy);
      chk($sformatf("v%0d wr_ready", i), wr_ready, 1);
      @(posedge clk); #1;
      chk($sformatf("v%0d ram_ctl", i), {ram_enb, ram_wr, ram_rd}, tv[i].e_ram);
      if (tv[i].e_ram[1] || tv[i].e_ram == 3'b000)
        chk($sformatf("v%0d ram_w", i), {ram_w_addr, ram_w_data}, {tv[i].e_wa, tv[i].e_wd});
      if (tv[i].e_ram[0] || tv[i].e_ram == 3'b000)
        chk($sformatf("v%0d ram_r_addr", i), ram_r_addr, tv[i].e_ra);
      chk($sformatf("v%0d rsp_valid", i), rsp_valid, tv[i].e_v);
      if (tv[i].e_v)
        chk($sformatf("v%0d rsp", i), {rsp_data, rsp_err}, {tv[i].e_d, tv[i].e_err});
      chk($sformatf("v%0d err_cnt", i), err_cnt, tv[i].e_ec);
    end

    // backpressure: only RSP_DEPTH reads outstanding while responses are held
    acc = 0; got = 0; rdy_s = 1; rsp_ready = 0;
    repeat (12) begin
      @(negedge clk);
      wr_valid = 0; rd_valid = (acc < 6); rd_addr = (acc < 6) ? bp_addr[acc] : 5'd0;
      #1 rdy_s = rd_ready;
      @(posedge clk);
      if (rd_valid && rdy_s) acc++;
    end
    chk("bp_accepted", acc, 4);
    chk("bp_rd_ready", rdy_s, 0);
    #1 chk("bp_head_stable", {rsp_valid, rsp_data, rsp_err}, {1'b1, 8'hA5, 1'b0});
    rsp_ready = 1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      rd_valid = (acc < 6); rd_addr = (acc < 6) ? bp_addr[acc] : 5'd0;
      #1 rdy_s = rd_ready; v_s = rsp_valid; d_s = rsp_data; e_s = rsp_err;
      @(posedge clk);
      if (rd_valid && rdy_s) acc++;
      if (v_s) begin
        chk($sformatf("bp_rsp%0d", got), {d_s, e_s}, {bp_exp[got], 1'b0});
        got++;
      end
    end
    chk("bp_accept_total", acc, 6);
    chk("bp_rsp_total", got, 6);

    // reset with one buffered response and two reads in flight
    @(negedge clk); rd_valid = 1; rd_addr = 5'd3; rsp_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", {rsp_valid, ram_rd, err_cnt}, {1'b1, 1'b1, 8'd3});
    #2 rst = 0;
    rd_valid = 0; wr_valid = 1; wr_addr = 5'd9; wr_data = 8'h77; rsp_ready = 1;
    #1;
    chk("rst_async_ctl", {wr_ready, rd_ready, rsp_valid, rsp_err, ram_enb, ram_wr, ram_rd}, 0);
    chk("rst_async_data", {rsp_data, err_cnt, ram_w_data, ram_w_addr, ram_r_addr}, 0);
    @(negedge clk); rst = 1;
    #1 chk("rst_release_ready", {wr_ready, rd_ready}, 2'b11);
    @(posedge clk); #1;
    chk("first_edge_write", {ram_wr, ram_w_addr, ram_w_data}, {1'b1, 5'd9, 8'h77});
    stay0 = 1'b0;
    repeat (5) begin
      @(negedge clk); wr_valid = 0;
      stay0 = stay0 | rsp_valid;
    end
    chk("rst_rsp_flushed", stay0, 0);
    chk("rst_credits", dut.credits, 0);

    // saturation of the error counter
    any_enb = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      wr_valid = 1; wr_addr = 5'(16 + (i % 16)); wr_data = 8'(i);
      @(posedge clk); #1;
      any_enb = any_enb | ram_enb;
      if (i == 253) chk("err_cnt_254", err_cnt, 8'hFE);
    end
    @(negedge clk); wr_valid = 0;
    chk("err_cnt_sat", err_cnt, 8'hFF);
    chk("oor_no_ram", any_enb, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
